control_unit_mc: RTL and testbench

- Parametrised multi-cycle control sequencer for the RISC datapath: register file, T1/T2 temporaries, C1 constant, MAR/MDR, IR and ALU.
- Holds a registered state plus a latched copy of the IR fields, and drives Moore control strobes to the datapath.
- New relative to the previous generation:
  - asynchronous reset with a defined idle state
  - parametrised instruction and register-address widths
  - memory wait states via mem_ready
  - HALT state and an illegal-opcode flag
  - optional conditional branch

---
 rtl/cu_pkg.sv | 86 ++++++++
 rtl/cu_decode.sv | 133 +++++++++++++
 rtl/control_unit_mc.sv | 175 +++++++++++++++++
 tb/tb_control_unit_mc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the multi-cycle control sequencer:
//   - cu_state_e    : sequencer states (IDLE, fetch, decode, execute, branch, HALT)
//   - OP_*          : opcode values (compared against the zero-extended opcode)
//   - ALU_*         : ALU operation codes driven on alu_op
//   - cu_strobes_t  : the Moore strobe bundle produced by cu_decode
//   - alu_for_opcode: ALU operation used by a register-register/shift opcode
// -----------------------------------------------------------------------------
package cu_pkg;

  localparam int CU_STATE_W = 5;

  typedef enum logic [CU_STATE_W-1:0] {
    IDLE,
    F0, F1, F2,
    D0,
    E0, E1, E2, E3, E4, E5, E6, E7,
    B0, B1, B2, B3, B4,
    HALT
  } cu_state_e;

  // Opcodes as integers so they compare cleanly with any OPC_W.
  localparam int OP_NOP   = 'h0;
  localparam int OP_ADD   = 'h1;
  localparam int OP_SUB   = 'h2;
  localparam int OP_AND   = 'h3;
  localparam int OP_OR    = 'h4;
  localparam int OP_XOR   = 'h5;
  localparam int OP_SHL   = 'h6;
  localparam int OP_SHR   = 'h7;
  localparam int OP_ADD2  = 'h8;
  localparam int OP_SUB2  = 'h9;
  localparam int OP_LOAD  = 'hA;
  localparam int OP_STORE = 'hB;
  localparam int OP_LINK  = 'hC;
  localparam int OP_BEQZ  = 'hD;
  localparam int OP_HALT  = 'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SHL  = 3'b110;
  localparam logic [2:0] ALU_SHR  = 3'b111;

  typedef struct packed {
    logic       reg_r;
    logic       reg_w;
    logic       t1ce;
    logic       t1oe;
    logic       t2ce;
    logic       t2oe;
    logic       pcoe;
    logic       c1oe;
    logic       marce;
    logic       maroe;
    logic       mdrce;
    logic       mdroe;
    logic       mdrget;
    logic       mem_read;
    logic       mem_write;
    logic       irce;
    logic [2:0] alu_op;
    logic       imm_oe;
    logic       halted;
  } cu_strobes_t;

  localparam int CU_STRB_W = $bits(cu_strobes_t);

  function automatic logic [2:0] alu_for_opcode(input logic [31:0] opc);
    case (opc)
      OP_ADD, OP_ADD2: return ALU_ADD;
      OP_SUB, OP_SUB2: return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_XOR:          return ALU_XOR;
      OP_SHL:          return ALU_SHL;
      OP_SHR:          return ALU_SHR;
      default:         return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// -----------------------------------------------------------------------------
// cu_decode
// Pure combinational map from sequencer state plus latched IR fields to the
// datapath strobe vector. Optional BEQZ strobes are built only when
// CU_BRANCH_EN is defined; otherwise B-states decode to all zeros and imm_oe
// is constant 0.
// Ports:
//   state_i     in  CU_STATE_W  current sequencer state (cu_state_e encoding)
//   opc_i       in  OPC_W       latched opcode
//   dst_i       in  REG_AW      latched destination field
//   srcx_i      in  REG_AW      latched source-x field
//   srcy_i      in  REG_AW      latched source-y field
//   strobes_o   out CU_STRB_W   packed cu_strobes_t
//   reg_addr_o  out REG_AW      register-file address (0 when unused)
// -----------------------------------------------------------------------------
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int REG_AW = 4,
  parameter int PC_REG = 2**REG_AW - 1
) (
  input  logic [CU_STATE_W-1:0] state_i,
  input  logic [OPC_W-1:0]      opc_i,
  input  logic [REG_AW-1:0]     dst_i,
  input  logic [REG_AW-1:0]     srcx_i,
  input  logic [REG_AW-1:0]     srcy_i,
  output logic [CU_STRB_W-1:0]  strobes_o,
  output logic [REG_AW-1:0]     reg_addr_o
);

  localparam logic [REG_AW-1:0] PC_ADDR = REG_AW'(PC_REG);

  cu_state_e         st;
  logic [31:0]       opc_wide;
  logic              is_link;
  logic              is_store;
  cu_strobes_t       s;
  logic [REG_AW-1:0] ra;

  assign st       = cu_state_e'(state_i);
  assign opc_wide = 32'(opc_i);
  assign is_link  = (opc_wide == 32'(OP_LINK));
  assign is_store = (opc_wide == 32'(OP_STORE));

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value held, which would otherwise infer a latch.
    s  = '0;
    ra = '0;
    case (st)
      F0: begin
        s.reg_r = 1'b1; s.pcoe = 1'b1; ra = PC_ADDR; s.t1ce = 1'b1; s.marce = 1'b1;
      end
      F1: begin
        s.t1oe = 1'b1; s.alu_op = ALU_ADD; s.c1oe = 1'b1; s.t2ce = 1'b1;
        s.maroe = 1'b1; s.mem_read = 1'b1; s.mdrce = 1'b1;
      end
      F2: begin
        s.mdroe = 1'b1; s.mdrget = 1'b1; s.irce = 1'b1;
      end
      D0: begin
        s.reg_w = 1'b1; s.pcoe = 1'b1; ra = PC_ADDR; s.t2oe = 1'b1; s.alu_op = ALU_PASS;
      end
      // E0..E2 are shared by the three-register ops and LINK (PC+1 -> dst).
      E0: begin
        s.reg_r = 1'b1; s.t1ce = 1'b1;
        if (is_link) begin
          s.pcoe = 1'b1; ra = PC_ADDR;
        end else begin
          ra = srcx_i;
        end
      end
      E1: begin
        s.t1oe = 1'b1; s.t2ce = 1'b1;
        if (is_link) begin
          s.c1oe = 1'b1; s.alu_op = ALU_ADD;
        end else begin
          s.reg_r = 1'b1; ra = srcy_i; s.alu_op = alu_for_opcode(opc_wide);
        end
      end
      E2, E4: begin
        s.reg_w = 1'b1; ra = dst_i; s.t2oe = 1'b1;
      end
      E3: begin
        s.reg_r = 1'b1; ra = srcx_i; s.t1oe = 1'b1; s.t2ce = 1'b1;
        s.alu_op = alu_for_opcode(opc_wide);
      end
      E5: begin
        s.reg_r = 1'b1; ra = srcx_i; s.marce = 1'b1;
      end
      E6: begin
        s.mdrce = 1'b1;
        if (is_store) begin
          s.reg_r = 1'b1; ra = dst_i;
        end else begin
          s.maroe = 1'b1; s.mem_read = 1'b1;
        end
      end
      E7: begin
        s.mdroe = 1'b1;
        if (is_store) begin
          s.maroe = 1'b1; s.mem_write = 1'b1;
        end else begin
          s.reg_w = 1'b1; ra = dst_i; s.mdrget = 1'b1;
        end
      end
`ifdef CU_BRANCH_EN
      B0: begin
        s.reg_r = 1'b1; ra = dst_i; s.t1ce = 1'b1;
      end
      B1: begin
        s.t1oe = 1'b1; s.alu_op = ALU_PASS; s.t2ce = 1'b1;
      end
      B2: begin
        s.reg_r = 1'b1; s.pcoe = 1'b1; ra = PC_ADDR; s.t1ce = 1'b1;
      end
      B3: begin
        s.t1oe = 1'b1; s.imm_oe = 1'b1; s.alu_op = ALU_ADD; s.t2ce = 1'b1;
      end
      B4: begin
        s.reg_w = 1'b1; s.pcoe = 1'b1; ra = PC_ADDR; s.t2oe = 1'b1;
      end
`endif
      HALT:    s.halted = 1'b1;
      default: ;
    endcase
  end

  assign strobes_o  = s;
  assign reg_addr_o = ra;

endmodule

// File: rtl/control_unit_mc.sv
// -----------------------------------------------------------------------------
// control_unit_mc
// Multi-cycle control sequencer for the RISC datapath. Holds the state
// register, a latched copy of the IR fields and the sticky illegal flag; all
// strobes are a Moore decode (cu_decode) of that registered state.
// Optional feature: define CU_BRANCH_EN to add BEQZ (opcode 0xD, B0..B4 and
// imm_oe). Without it 0xD is illegal, imm_oe is 0 and alu_zero is ignored.
// Ports:
//   clk, rst (async, active high), instruction [INSTR_W], mem_ready, alu_zero
//   reg_r, reg_w, reg_addr [REG_AW], t1ce, t1oe, t2ce, t2oe, pcoe, c1oe,
//   marce, maroe, mdrce, mdroe, mdrget, mem_read, mem_write, irce,
//   alu_op [3], imm_oe, halted, illegal
// -----------------------------------------------------------------------------
module control_unit_mc
  import cu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_AW  = 4,
  parameter int PC_REG  = 2**REG_AW - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic               reg_r,
  output logic               reg_w,
  output logic [REG_AW-1:0]  reg_addr,
  output logic               t1ce,
  output logic               t1oe,
  output logic               t2ce,
  output logic               t2oe,
  output logic               pcoe,
  output logic               c1oe,
  output logic               marce,
  output logic               maroe,
  output logic               mdrce,
  output logic               mdroe,
  output logic               mdrget,
  output logic               mem_read,
  output logic               mem_write,
  output logic               irce,
  output logic [2:0]         alu_op,
  output logic               imm_oe,
  output logic               halted,
  output logic               illegal
);

  if (INSTR_W != OPC_W + 3*REG_AW) begin : g_bad_cfg
    $error("control_unit_mc: INSTR_W must equal OPC_W + 3*REG_AW");
  end

  cu_state_e          state_q;
  logic [OPC_W-1:0]   opc_q;
  logic [REG_AW-1:0]  dst_q;
  logic [REG_AW-1:0]  srcx_q;
  logic [REG_AW-1:0]  srcy_q;
  logic               illegal_q;

  logic [31:0]        opc_wide;
  logic               is_store;

  // Zero-extend so opcodes wider than 4 bits at or above 0x10 fall to default.
  assign opc_wide = 32'(opc_q);
  assign is_store = (opc_wide == 32'(OP_STORE));

`ifndef CU_BRANCH_EN
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      // NOTE: the field latch is reset along with the state because the decode
      // reads it; leaving it X would propagate into reg_addr/alu_op.
      opc_q     <= '0;
      dst_q     <= '0;
      srcx_q    <= '0;
      srcy_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      case (state_q)
        IDLE: state_q <= F0;
        F0:   state_q <= F1;
        F1:   if (mem_ready) state_q <= F2;
        F2: begin
          state_q <= D0;
          opc_q   <= instruction[INSTR_W-1 -: OPC_W];
          dst_q   <= instruction[3*REG_AW-1 -: REG_AW];
          srcx_q  <= instruction[2*REG_AW-1 -: REG_AW];
          srcy_q  <= instruction[REG_AW-1:0];
        end
        D0: begin
          case (opc_wide)
            OP_NOP:                                 state_q <= F0;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_ADD2, OP_SUB2, OP_LINK:              state_q <= E0;
            OP_SHL, OP_SHR:                         state_q <= E3;
            OP_LOAD, OP_STORE:                      state_q <= E5;
            OP_HALT:                                state_q <= HALT;
`ifdef CU_BRANCH_EN
            OP_BEQZ:                                state_q <= B0;
`endif
            default: begin
              illegal_q <= 1'b1;
              state_q   <= F0;
            end
          endcase
        end
        E0: state_q <= E1;
        E1: state_q <= E2;
        E2: state_q <= F0;
        E3: state_q <= E4;
        E4: state_q <= F0;
        E5: state_q <= E6;
        // LOAD waits for the read in E6; STORE waits for the write in E7.
        E6: if (is_store || mem_ready) state_q <= E7;
        E7: if (!is_store || mem_ready) state_q <= F0;
`ifdef CU_BRANCH_EN
        B0: state_q <= B1;
        B1: state_q <= alu_zero ? B2 : F0;
        B2: state_q <= B3;
        B3: state_q <= B4;
        B4: state_q <= F0;
`endif
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [CU_STRB_W-1:0] strobes;
  cu_strobes_t          strb;

  cu_decode #(
    .OPC_W  (OPC_W),
    .REG_AW (REG_AW),
    .PC_REG (PC_REG)
  ) u_decode (
    .state_i    (state_q),
    .opc_i      (opc_q),
    .dst_i      (dst_q),
    .srcx_i     (srcx_q),
    .srcy_i     (srcy_q),
    .strobes_o  (strobes),
    .reg_addr_o (reg_addr)
  );

  assign strb      = cu_strobes_t'(strobes);
  assign reg_r     = strb.reg_r;
  assign reg_w     = strb.reg_w;
  assign t1ce      = strb.t1ce;
  assign t1oe      = strb.t1oe;
  assign t2ce      = strb.t2ce;
  assign t2oe      = strb.t2oe;
  assign pcoe      = strb.pcoe;
  assign c1oe      = strb.c1oe;
  assign marce     = strb.marce;
  assign maroe     = strb.maroe;
  assign mdrce     = strb.mdrce;
  assign mdroe     = strb.mdroe;
  assign mdrget    = strb.mdrget;
  assign mem_read  = strb.mem_read;
  assign mem_write = strb.mem_write;
  assign irce      = strb.irce;
  assign alu_op    = strb.alu_op;
  assign imm_oe    = strb.imm_oe;
  assign halted    = strb.halted;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_control_unit_mc
// Scoreboard bench: the driver pushes the hand-derived output snapshot that
// each cycle must show; an independent monitor pops and compares after every
// rising edge, or immediately after an asynchronous reset request.
// -----------------------------------------------------------------------------
module tb_control_unit_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instruction = 16'h0000;
  logic        mem_ready = 1'b1;
  logic        alu_zero = 1'b0;
  logic        snap = 1'b0;

  logic       reg_r, reg_w, t1ce, t1oe, t2ce, t2oe, pcoe, c1oe;
  logic       marce, maroe, mdrce, mdroe, mdrget, mem_read, mem_write, irce;
  logic       imm_oe, halted, illegal;
  logic [3:0] reg_addr;
  logic [2:0] alu_op;

  control_unit_mc #(
    .INSTR_W (16),
    .OPC_W   (4),
    .REG_AW  (4),
    .PC_REG  (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .mem_ready   (mem_ready),
    .alu_zero    (alu_zero),
    .reg_r       (reg_r),
    .reg_w       (reg_w),
    .reg_addr    (reg_addr),
    .t1ce        (t1ce),
    .t1oe        (t1oe),
    .t2ce        (t2ce),
    .t2oe        (t2oe),
    .pcoe        (pcoe),
    .c1oe        (c1oe),
    .marce       (marce),
    .maroe       (maroe),
    .mdrce       (mdrce),
    .mdroe       (mdroe),
    .mdrget      (mdrget),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .irce        (irce),
    .alu_op      (alu_op),
    .imm_oe      (imm_oe),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {
    T_IDLE, T_F0, T_F1, T_F2, T_D0,
    T_E0, T_E1, T_E2, T_E3, T_E4, T_E5, T_E6, T_E7,
    T_B0, T_B1, T_B2, T_B3, T_B4, T_HALT
  } tst_e;

  typedef struct packed {
    logic       reg_r;
    logic       reg_w;
    logic [3:0] reg_addr;
    logic       t1ce, t1oe, t2ce, t2oe, pcoe, c1oe;
    logic       marce, maroe, mdrce, mdroe, mdrget;
    logic       mem_read, mem_write, irce;
    logic [2:0] alu_op;
    logic       imm_oe, halted, illegal;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string tag = "";

  // Hand-supplied fields of the instruction currently executing.
  logic [3:0] f_dst = 4'h0, f_srcx = 4'h0, f_srcy = 4'h0;
  logic [2:0] f_alu = 3'b000;
  logic       f_link = 1'b0, f_store = 1'b0, f_ill = 1'b0;

  task automatic check(input string nm, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b (reg_r,reg_w,addr,t1ce,t1oe,t2ce,t2oe,pcoe,c1oe,marce,maroe,mdrce,mdroe,mdrget,rd,wr,irce,alu,imm,halt,ill)",
               nm, act, exp);
    end
  endtask

  // Expected outputs per state, taken from the control table.
  function automatic obs_t model(input tst_e st);
    obs_t o;
    o = '0;
    o.illegal = f_ill;
    case (st)
      T_F0: begin o.reg_r = 1; o.pcoe = 1; o.reg_addr = 4'hF; o.t1ce = 1; o.marce = 1; end
      T_F1: begin o.t1oe = 1; o.alu_op = 3'b001; o.c1oe = 1; o.t2ce = 1;
                  o.maroe = 1; o.mem_read = 1; o.mdrce = 1; end
      T_F2: begin o.mdroe = 1; o.mdrget = 1; o.irce = 1; end
      T_D0: begin o.reg_w = 1; o.pcoe = 1; o.reg_addr = 4'hF; o.t2oe = 1; end
      T_E0: if (f_link) begin o.reg_r = 1; o.pcoe = 1; o.reg_addr = 4'hF; o.t1ce = 1; end
            else        begin o.reg_r = 1; o.reg_addr = f_srcx; o.t1ce = 1; end
      T_E1: if (f_link) begin o.t1oe = 1; o.c1oe = 1; o.alu_op = 3'b001; o.t2ce = 1; end
            else        begin o.reg_r = 1; o.reg_addr = f_srcy; o.t1oe = 1; o.t2ce = 1; o.alu_op = f_alu; end
      T_E2, T_E4: begin o.reg_w = 1; o.reg_addr = f_dst; o.t2oe = 1; end
      T_E3: begin o.reg_r = 1; o.reg_addr = f_srcx; o.t1oe = 1; o.t2ce = 1; o.alu_op = f_alu; end
      T_E5: begin o.reg_r = 1; o.reg_addr = f_srcx; o.marce = 1; end
      T_E6: if (f_store) begin o.reg_r = 1; o.reg_addr = f_dst; o.mdrce = 1; end
            else         begin o.maroe = 1; o.mdrce = 1; o.mem_read = 1; end
      T_E7: if (f_store) begin o.maroe = 1; o.mdroe = 1; o.mem_write = 1; end
            else         begin o.reg_w = 1; o.reg_addr = f_dst; o.mdroe = 1; o.mdrget = 1; end
      T_B0: begin o.reg_r = 1; o.reg_addr = f_dst; o.t1ce = 1; end
      T_B1: begin o.t1oe = 1; o.t2ce = 1; end
      T_B2: begin o.reg_r = 1; o.pcoe = 1; o.reg_addr = 4'hF; o.t1ce = 1; end
      T_B3: begin o.t1oe = 1; o.imm_oe = 1; o.alu_op = 3'b001; o.t2ce = 1; end
      T_B4: begin o.reg_w = 1; o.pcoe = 1; o.reg_addr = 4'hF; o.t2oe = 1; end
      T_HALT: o.halted = 1;
      default: ;
    endcase
    return o;
  endfunction

  // Push the snapshot expected after the next rising edge, then move to the
  // following falling edge where the driver may change inputs again.
  task automatic cyc(input tst_e st);
    item_t it;
    it.name = {tag, ":", st.name()};
    it.exp  = model(st);
    sb_q.push_back(it);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle; outputs must clear before the next clock edge.
  task automatic async_rst();
    item_t it;
    rst   = 1'b1;
    f_ill = 1'b0;
    it.name = {tag, ":async_rst"};
    it.exp  = '0;
    sb_q.push_back(it);
    snap = 1'b1;
    #1 snap = 1'b0;
    cyc(T_IDLE);
    rst = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] ins, input int waits);
    instruction = ins;
    cyc(T_F0);
    cyc(T_F1);
    repeat (waits) begin
      mem_ready = 1'b0;
      cyc(T_F1);
    end
    mem_ready = 1'b1;
    cyc(T_F2);
    cyc(T_D0);
  endtask

  task automatic set_fields(input logic [3:0] d, input logic [3:0] x, input logic [3:0] y,
                            input logic [2:0] alu, input logic link, input logic store);
    f_dst = d; f_srcx = x; f_srcy = y; f_alu = alu; f_link = link; f_store = store;
  endtask

  // Monitor: compare one queued snapshot per observation point.
  initial begin
    item_t it;
    obs_t  act;
    forever begin
      @(posedge clk or posedge snap);
      #2;
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {reg_r, reg_w, reg_addr, t1ce, t1oe, t2ce, t2oe, pcoe, c1oe,
               marce, maroe, mdrce, mdroe, mdrget, mem_read, mem_write, irce,
               alu_op, imm_oe, halted, illegal};
        check(it.name, act, it.exp);
      end
    end
  end

  initial begin
    @(negedge clk);
    tag = "reset"; async_rst();

    tag = "nop";   set_fields(4'h0, 4'h0, 4'h0, 3'b000, 0, 0); fetch(16'h0000, 0);

    tag = "add";   set_fields(4'h1, 4'h2, 4'h3, 3'b001, 0, 0); fetch(16'h1123, 0);
    cyc(T_E0); cyc(T_E1); cyc(T_E2);

    tag = "sub9";  set_fields(4'hA, 4'hB, 4'hC, 3'b010, 0, 0); fetch(16'h9ABC, 2);
    cyc(T_E0); cyc(T_E1); cyc(T_E2);

    tag = "and";   set_fields(4'h4, 4'h5, 4'h6, 3'b011, 0, 0); fetch(16'h3456, 0);
    cyc(T_E0); cyc(T_E1); cyc(T_E2);

    tag = "xor";   set_fields(4'h0, 4'hE, 4'h7, 3'b101, 0, 0); fetch(16'h50E7, 0);
    cyc(T_E0); cyc(T_E1); cyc(T_E2);

    tag = "shl";   set_fields(4'h1, 4'h2, 4'h0, 3'b110, 0, 0); fetch(16'h6120, 0);
    cyc(T_E3); cyc(T_E4);

    tag = "shr";   set_fields(4'h8, 4'h9, 4'h0, 3'b111, 0, 0); fetch(16'h7890, 0);
    cyc(T_E3); cyc(T_E4);

    tag = "load";  set_fields(4'h4, 4'h5, 4'h0, 3'b000, 0, 0); fetch(16'hA450, 0);
    cyc(T_E5); cyc(T_E6);
    repeat (3) begin mem_ready = 1'b0; cyc(T_E6); end
    mem_ready = 1'b1; cyc(T_E7);

    tag = "store"; set_fields(4'h6, 4'h7, 4'h0, 3'b000, 0, 1); fetch(16'hB670, 0);
    cyc(T_E5);
    mem_ready = 1'b0; cyc(T_E6);   // STORE does not wait in E6
    cyc(T_E7);
    repeat (2) cyc(T_E7);
    mem_ready = 1'b1;

    tag = "link";  set_fields(4'h3, 4'h0, 4'h0, 3'b000, 1, 0); fetch(16'hC300, 0);
    cyc(T_E0); cyc(T_E1); cyc(T_E2);

`ifdef CU_BRANCH_EN
    tag = "beqz_taken"; set_fields(4'h2, 4'hF, 4'hE, 3'b000, 0, 0); fetch(16'hD2FE, 0);
    alu_zero = 1'b1;
    cyc(T_B0); cyc(T_B1); cyc(T_B2); cyc(T_B3); cyc(T_B4);
    tag = "beqz_fall"; alu_zero = 1'b0; fetch(16'hD2FE, 0);
    cyc(T_B0); cyc(T_B1);
`else
    tag = "opD_illegal"; set_fields(4'h2, 4'hF, 4'hE, 3'b000, 0, 0); fetch(16'hD2FE, 0);
    f_ill = 1'b1;
`endif

    tag = "undef"; set_fields(4'h0, 4'h0, 4'h0, 3'b000, 0, 0); fetch(16'hE000, 0);
    f_ill = 1'b1;

    tag = "halt";  fetch(16'hF000, 0);
    cyc(T_HALT);
    mem_ready = 1'b0; cyc(T_HALT);
    mem_ready = 1'b1; cyc(T_HALT); cyc(T_HALT);

    tag = "rst_in_halt"; async_rst();
    tag = "after_halt";  set_fields(4'h1, 4'h2, 4'h3, 3'b001, 0, 0); fetch(16'h1123, 0);
    cyc(T_E0); cyc(T_E1); cyc(T_E2);

    tag = "rst_in_f1";
    instruction = 16'h0000;
    cyc(T_F0); cyc(T_F1);
    mem_ready = 1'b0; cyc(T_F1);
    async_rst();
    mem_ready = 1'b1;
    tag = "restart"; fetch(16'h0000, 0);
    cyc(T_F0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d snapshots left unchecked, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
